cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm.sv | 143 ++++++++++++++
 tb/tb_cpu_control_fsm.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/writeback controller with registered outputs
module cpu_control_fsm #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IMEM_BUSYWAIT,
  input  logic        ZERO,
  output logic        IMEM_READ,
  output logic [2:0]  ALUOP,
  output logic        IMMSEL,
  output logic        NEGSEL,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic [7:0]  IMMEDIATE,
  output logic [7:0]  OFFSET,
  output logic        REG_WRITE,
  output logic        PC_EN,
  output logic        JUMP,
  output logic        BRANCH_TAKEN,
  output logic        ILLEGAL
);
  typedef enum logic [2:0] {RST, FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t      state, state_d;
  logic [31:0] ir, ir_d;
  logic [3:0]  cnt, cnt_d;
  logic [7:0]  op;
  logic        imem_read_d, immsel_d, negsel_d, reg_write_d, pc_en_d, jump_d, branch_d, illegal_d;
  logic [2:0]  aluop_d, rr1_d, rr2_d, wr_d;
  logic [7:0]  imm_d, off_d;
  logic        unused_ir_bits;
  assign op = ir[31:24];
  assign unused_ir_bits = ^ir[15:11];
  // Next state plus the value every output register takes on the coming edge;
  // outputs are computed for the state being entered so they are valid throughout it.
  always_comb begin
    state_d = state;
    ir_d = ir;
    cnt_d = cnt;
    imem_read_d = 1'b0;
    aluop_d = ALUOP;
    immsel_d = IMMSEL;
    negsel_d = NEGSEL;
    rr1_d = READREG1;
    rr2_d = READREG2;
    wr_d = WRITEREG;
    imm_d = IMMEDIATE;
    off_d = OFFSET;
    reg_write_d = 1'b0;
    pc_en_d = 1'b0;
    jump_d = 1'b0;
    branch_d = 1'b0;
    illegal_d = ILLEGAL;
    case (state)
      RST: begin
        state_d = FETCH;
        imem_read_d = 1'b1;
      end
      FETCH: begin
        state_d = IMEM_BUSYWAIT ? FETCH : DECODE;
        imem_read_d = IMEM_BUSYWAIT;
        ir_d = IMEM_BUSYWAIT ? ir : INSTRUCTION;
      end
      DECODE: begin
        if (op > 8'h07) begin
          state_d = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXECUTE;
          cnt_d = 4'(EXEC_CYCLES - 1);
          aluop_d = (op == 8'h02 || op == 8'h03 || op == 8'h07) ? 3'b001 :
                    (op == 8'h04) ? 3'b010 : (op == 8'h05) ? 3'b011 : 3'b000;
          immsel_d = op == 8'h00;
          negsel_d = op == 8'h03 || op == 8'h07;
          rr1_d = ir[10:8];
          rr2_d = ir[2:0];
          wr_d = ir[18:16];
          imm_d = ir[7:0];
          off_d = ir[23:16];
        end
      end
      EXECUTE: begin
        if (cnt == 4'd0) begin
          state_d = WRITEBACK;
          pc_en_d = 1'b1;
          reg_write_d = op <= 8'h05;
          jump_d = op == 8'h06;
          branch_d = op == 8'h07 && ZERO;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      WRITEBACK: begin
        state_d = FETCH;
        imem_read_d = 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = RST;
    endcase
  end
  // State, IR, counter and all output registers; reset clears them without a clock
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= RST;
      ir <= '0;
      cnt <= '0;
      IMEM_READ <= 1'b0;
      ALUOP <= '0;
      IMMSEL <= 1'b0;
      NEGSEL <= 1'b0;
      READREG1 <= '0;
      READREG2 <= '0;
      WRITEREG <= '0;
      IMMEDIATE <= '0;
      OFFSET <= '0;
      REG_WRITE <= 1'b0;
      PC_EN <= 1'b0;
      JUMP <= 1'b0;
      BRANCH_TAKEN <= 1'b0;
      ILLEGAL <= 1'b0;
    end else begin
      state <= state_d;
      ir <= ir_d;
      cnt <= cnt_d;
      IMEM_READ <= imem_read_d;
      ALUOP <= aluop_d;
      IMMSEL <= immsel_d;
      NEGSEL <= negsel_d;
      READREG1 <= rr1_d;
      READREG2 <= rr2_d;
      WRITEREG <= wr_d;
      IMMEDIATE <= imm_d;
      OFFSET <= off_d;
      REG_WRITE <= reg_write_d;
      PC_EN <= pc_en_d;
      JUMP <= jump_d;
      BRANCH_TAKEN <= branch_d;
      ILLEGAL <= illegal_d;
    end
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed checks of the control FSM at EXEC_CYCLES = 2, 1 and 4
module tb_cpu_control_fsm;
  logic        CLK, RESET, busy, ZERO;
  logic [31:0] INSTRUCTION;
  int          total = 0, bad = 0;
  logic        imem_read, immsel, negsel, reg_write, pc_en, jump, bt, illegal;
  logic [2:0]  aluop, rr1, rr2, wr;
  logic [7:0]  imm, off;
  logic        a_imem_read, a_immsel, a_negsel, a_reg_write, a_pc_en, a_jump, a_bt, a_illegal;
  logic [2:0]  a_aluop, a_rr1, a_rr2, a_wr;
  logic [7:0]  a_imm, a_off;
  logic        b_imem_read, b_immsel, b_negsel, b_reg_write, b_pc_en, b_jump, b_bt, b_illegal;
  logic [2:0]  b_aluop, b_rr1, b_rr2, b_wr;
  logic [7:0]  b_imm, b_off;

  cpu_control_fsm #(.EXEC_CYCLES(2)) u0 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IMEM_BUSYWAIT(busy), .ZERO(ZERO),
    .IMEM_READ(imem_read), .ALUOP(aluop), .IMMSEL(immsel), .NEGSEL(negsel),
    .READREG1(rr1), .READREG2(rr2), .WRITEREG(wr), .IMMEDIATE(imm), .OFFSET(off),
    .REG_WRITE(reg_write), .PC_EN(pc_en), .JUMP(jump), .BRANCH_TAKEN(bt), .ILLEGAL(illegal));
  cpu_control_fsm #(.EXEC_CYCLES(1)) u1 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IMEM_BUSYWAIT(busy), .ZERO(ZERO),
    .IMEM_READ(a_imem_read), .ALUOP(a_aluop), .IMMSEL(a_immsel), .NEGSEL(a_negsel),
    .READREG1(a_rr1), .READREG2(a_rr2), .WRITEREG(a_wr), .IMMEDIATE(a_imm), .OFFSET(a_off),
    .REG_WRITE(a_reg_write), .PC_EN(a_pc_en), .JUMP(a_jump), .BRANCH_TAKEN(a_bt), .ILLEGAL(a_illegal));
  cpu_control_fsm #(.EXEC_CYCLES(4)) u4 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IMEM_BUSYWAIT(busy), .ZERO(ZERO),
    .IMEM_READ(b_imem_read), .ALUOP(b_aluop), .IMMSEL(b_immsel), .NEGSEL(b_negsel),
    .READREG1(b_rr1), .READREG2(b_rr2), .WRITEREG(b_wr), .IMMEDIATE(b_imm), .OFFSET(b_off),
    .REG_WRITE(b_reg_write), .PC_EN(b_pc_en), .JUMP(b_jump), .BRANCH_TAKEN(b_bt), .ILLEGAL(b_illegal));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0; busy = 1'b0; ZERO = 1'b0; INSTRUCTION = 32'h0002002A;
    tick(); tick();
    chk("rst_out", {imem_read, reg_write, pc_en, illegal, immsel, aluop}, 32'h0);
    RESET = 1'b1;
    tick(); chk("li_fetch_read", imem_read, 1);
    tick(); chk("li_decode_read", imem_read, 0);
    tick();
    chk("li_aluop", aluop, 0); chk("li_immsel", immsel, 1); chk("li_imm", imm, 8'h2A);
    chk("li_wr", wr, 2); chk("li_exec1_pc", pc_en, 0);
    tick();
    chk("li_exec2_rw", reg_write, 0); chk("li_exec2_immsel", immsel, 1);
    busy = 1'b1; INSTRUCTION = 32'h03040102;
    tick();
    chk("li_wb_rw", reg_write, 1); chk("li_wb_pc", pc_en, 1); chk("li_wb_jump", jump, 0);
    chk("li_wb_immsel", immsel, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("sub_stall_read", imem_read, 1); chk("sub_stall_rw", reg_write, 0);
    end
    busy = 1'b0;
    tick(); chk("sub_decode_read", imem_read, 0);
    tick();
    chk("sub_aluop", aluop, 1); chk("sub_negsel", negsel, 1); chk("sub_immsel", immsel, 0);
    chk("sub_rr1", rr1, 1); chk("sub_rr2", rr2, 2); chk("sub_wr", wr, 4); chk("sub_exec_rw", reg_write, 0);
    tick(); chk("sub_exec2_rw", reg_write, 0);
    INSTRUCTION = 32'h07FE0102; ZERO = 1'b1;
    tick(); chk("sub_wb_rw", reg_write, 1); chk("sub_wb_pc", pc_en, 1);
    tick(); chk("sub_after_rw", reg_write, 0); chk("sub_after_pc", pc_en, 0);
    tick();
    tick(); chk("beq_off", off, 8'hFE); chk("beq_negsel", negsel, 1); chk("beq_aluop", aluop, 1);
    tick();
    tick(); chk("beq1_pc", pc_en, 1); chk("beq1_bt", bt, 1); chk("beq1_rw", reg_write, 0);
    ZERO = 1'b0;
    tick(); chk("beq1_bt_drop", bt, 0);
    tick(); tick(); tick();
    tick(); chk("beq0_pc", pc_en, 1); chk("beq0_bt", bt, 0); chk("beq0_rw", reg_write, 0);
    chk("beq0_off", off, 8'hFE);
    INSTRUCTION = 32'h06100000;
    tick(); tick(); tick(); tick();
    tick(); chk("j_jump", jump, 1); chk("j_pc", pc_en, 1); chk("j_rw", reg_write, 0);
    INSTRUCTION = 32'h09000000;
    tick(); tick(); chk("ill_decode", illegal, 0);
    tick(); chk("ill_set", illegal, 1);
    for (int i = 0; i < 20; i++) begin
      tick(); chk("halt_pc_rw_rd_ill", {pc_en, reg_write, imem_read, illegal}, 4'b0001);
    end
    RESET = 1'b0;
    #1 chk("ill_clear", illegal, 0);
    tick();
    INSTRUCTION = 32'h02030102; RESET = 1'b1;
    tick(); chk("add_fetch", imem_read, 1);
    tick();
    tick(); chk("add_aluop", aluop, 1);
    #1 RESET = 1'b0;
    #1;
    chk("async_out_a", {imem_read, aluop, immsel, negsel, rr1, rr2, wr, imm}, 32'h0);
    chk("async_out_b", {off, reg_write, pc_en, jump, bt, illegal}, 32'h0);
    tick();
    RESET = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick(); chk("rel_rw", reg_write, c == 5);
    end
    RESET = 1'b0; INSTRUCTION = 32'h04010203;
    tick();
    RESET = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("and_e1_pc", a_pc_en, c == 4); chk("and_e4_pc", b_pc_en, c == 7);
      if (c >= 3) begin
        chk("and_e1_aluop", a_aluop, 2); chk("and_e4_aluop", b_aluop, 2);
      end
    end
    RESET = 1'b0; INSTRUCTION = 32'h05010203;
    tick();
    RESET = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("or_e1_pc", a_pc_en, c == 4); chk("or_e4_pc", b_pc_en, c == 7);
      if (c >= 3) begin
        chk("or_e1_aluop", a_aluop, 3); chk("or_e4_aluop", b_aluop, 3);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
